// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - funct3 codes, FSM states and size decode for the sized data memory
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  // Byte count of an access; only the low two funct3 bits carry the size.
  function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Power-up image of doublewords 0..7, little-endian packed from bit 0.
  function automatic logic [511:0] preset_image();
    logic [511:0] img;
    img          = '0;
    img[0*64+:64] = 64'd6;
    img[1*64+:64] = 64'd54;
    img[2*64+:64] = 64'd44;
    img[3*64+:64] = 64'd23;
    img[4*64+:64] = 64'd15;
    img[5*64+:64] = 64'd1;
    img[6*64+:64] = 64'd7;
    img[7*64+:64] = 64'd8;
    return img;
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// rtl/dmem_load_ext.sv - byte lane selection and sign/zero extension of load data
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [63:0] i_dword,
  input  logic [2:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [63:0] o_data
);

  logic [63:0] w_shifted;

  always_comb begin
    w_shifted = i_dword >> {i_offset, 3'b000};
    o_data    = '0;
    case (i_funct3)
      F3_B:    o_data = {{56{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
      F3_D:    o_data = w_shifted;
      F3_BU:   o_data = {56'd0, w_shifted[7:0]};
      F3_HU:   o_data = {48'd0, w_shifted[15:0]};
      F3_WU:   o_data = {32'd0, w_shifted[31:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// rtl/sized_data_memory.sv - little-endian byte memory with RISC-V sized loads/stores
module sized_data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES  = 256,
  parameter int READ_LATENCY = 1,
  parameter int INIT_PRESET  = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [2:0]                     req_funct3,
  input  logic [63:0]                    req_addr,
  input  logic [63:0]                    req_wdata,
  output logic                           rsp_valid,
  output logic [63:0]                    rsp_rdata,
  output logic                           rsp_err,
  input  logic [$clog2(DEPTH_BYTES)-1:0] dbg_addr,
  output logic [63:0]                    dbg_word
);

  localparam int AW       = $clog2(DEPTH_BYTES);
  localparam int MEM_BITS = 8 * DEPTH_BYTES;
  localparam int MB       = AW + 3;
  localparam int DWW      = (AW > 3) ? AW - 3 : 1;
  localparam logic [1:0] LAT_LAST = 2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  // Contents survive reset, so the array carries only a power-up value.
  logic [MEM_BITS-1:0] r_mem = (INIT_PRESET != 0) ? MEM_BITS'(preset_image()) : '0;

  state_t      r_state;
  logic [1:0]  r_lat_cnt;
  logic [63:0] r_rdata;
  logic        r_err;

  state_t      w_state_nxt;
  logic [1:0]  w_cnt_nxt;
  logic [3:0]  w_size;
  logic        w_illegal;
  logic        w_misalign;
  logic [64:0] w_end;
  logic        w_err;
  logic        w_accept;
  logic [DWW-1:0] w_dw;
  logic [DWW-1:0] w_dbg_dw;
  logic [MB-1:0]  w_base;
  logic [MB-1:0]  w_dbg_base;
  logic [63:0] w_rd_dword;
  logic [63:0] w_ld_data;
  logic [7:0]  w_be;
  logic [63:0] w_wdata_sh;

  assign w_size     = access_bytes(req_funct3);
  assign w_illegal  = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
  assign w_misalign = |(req_addr[3:0] & (w_size - 4'd1));
  // 65-bit sum so addresses near 2^64 cannot wrap back into range.
  assign w_end      = {1'b0, req_addr} + {61'd0, w_size};
  assign w_err      = w_illegal | w_misalign | (w_end > 65'(DEPTH_BYTES));
  assign w_accept   = req_valid && reset_n && (r_state == S_IDLE);

  assign w_dw       = DWW'(req_addr[AW-1:0] >> 3);
  assign w_base     = MB'({w_dw, 6'b000000});
  assign w_rd_dword = r_mem[w_base +: 64];

  assign w_dbg_dw   = DWW'(dbg_addr >> 3);
  assign w_dbg_base = MB'({w_dbg_dw, 6'b000000});
  assign dbg_word   = r_mem[w_dbg_base +: 64];

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   w_be = 8'h01;
      2'b01:   w_be = 8'h03;
      2'b10:   w_be = 8'h0F;
      default: w_be = 8'hFF;
    endcase
    w_be = w_be << req_addr[2:0];
  end

  assign w_wdata_sh = req_wdata << {req_addr[2:0], 3'b000};

  dmem_load_ext u_load_ext (
    .i_dword  (w_rd_dword),
    .i_offset (req_addr[2:0]),
    .i_funct3 (req_funct3),
    .o_data   (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (w_accept && req_write && !w_err) begin
      for (int b = 0; b < 8; b++) begin
        if (w_be[b]) r_mem[w_base + MB'(8 * b) +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_cnt_nxt;
      if (w_accept) begin
        r_rdata <= (req_write || w_err) ? 64'd0 : w_ld_data;
        r_err   <= w_err;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_lat_cnt;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_rdata   = '0;
    rsp_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          w_cnt_nxt = '0;
          if (req_write || w_err || (READ_LATENCY == 1)) w_state_nxt = S_RESP;
          else                                           w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_lat_cnt + 2'd1;
        end
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        rsp_rdata   = r_rdata;
        rsp_err     = r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sized_data_memory.sv
// tb/tb_sized_data_memory.sv - directed bench for sized_data_memory at read latencies 1 and 3
module tb_sized_data_memory;

  logic clk = 1'b0;
  logic reset_n;

  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_err;
  logic [2:0]  a_req_funct3;
  logic [63:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_dbg_word;
  logic [7:0]  a_dbg_addr;

  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_err;
  logic [2:0]  b_req_funct3;
  logic [63:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_dbg_word;
  logic [7:0]  b_dbg_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sized_data_memory #(.DEPTH_BYTES(256), .READ_LATENCY(1), .INIT_PRESET(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .dbg_addr(a_dbg_addr), .dbg_word(a_dbg_word)
  );

  sized_data_memory #(.DEPTH_BYTES(256), .READ_LATENCY(3), .INIT_PRESET(1)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .dbg_addr(b_dbg_addr), .dbg_word(b_dbg_word)
  );

  task automatic drive_req(input bit sel, input logic w, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    if (!sel) begin
      a_req_valid = 1'b1; a_req_write = w; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wdata;
    end else begin
      b_req_valid = 1'b1; b_req_write = w; b_req_funct3 = f3; b_req_addr = addr; b_req_wdata = wdata;
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic access(input bit sel, input logic w, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        output logic [63:0] rd, output logic er, output int lat);
    drive_req(sel, w, f3, addr, wdata);
    lat = 1;
    while (((sel ? b_rsp_valid : a_rsp_valid) !== 1'b1) && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = sel ? b_rsp_rdata : a_rsp_rdata;
    er = sel ? b_rsp_err : a_rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", a_req_ready); end
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", a_rsp_valid); end
    checks++; if (a_rsp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", a_rsp_rdata); end
    checks++; if (a_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", a_rsp_err); end
    a_dbg_addr = 8'd8; #1;
    checks++; if (a_dbg_word !== 64'd54) begin errors++; $display("FAIL preset_dbg8: got %h expected %h", a_dbg_word, 64'd54); end
    a_dbg_addr = 8'd63; #1;
    checks++; if (a_dbg_word !== 64'd8) begin errors++; $display("FAIL preset_dbg63: got %h expected %h", a_dbg_word, 64'd8); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_load();
    logic [63:0] rd; logic er; int lat;
    access(0, 1'b0, 3'b011, 64'd8, 64'd0, rd, er, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ld8_latency: got %0d expected 1", lat); end
    checks++; if (rd !== 64'd54) begin errors++; $display("FAIL ld8_data: got %h expected %h", rd, 64'd54); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL ld8_err: got %b expected 0", er); end
    access(0, 1'b0, 3'b010, 64'd24, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'd23) begin errors++; $display("FAIL lw24_data: got %h expected %h", rd, 64'd23); end
  endtask

  task automatic test_byte();
    logic [63:0] rd; logic er; int lat;
    access(0, 1'b1, 3'b000, 64'd3, 64'h1234_5678_9ABC_DEFF, rd, er, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sb3_latency: got %0d expected 1", lat); end
    checks++; if (rd !== 64'd0 || er !== 1'b0) begin errors++; $display("FAIL sb3_rsp: got %h/%b expected 0/0", rd, er); end
    access(0, 1'b0, 3'b000, 64'd3, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL lb3: got %h expected ffffffffffffffff", rd); end
    access(0, 1'b0, 3'b100, 64'd3, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'h0000_0000_0000_00FF) begin errors++; $display("FAIL lbu3: got %h expected ff", rd); end
    a_dbg_addr = 8'd0; #1;
    checks++; if (a_dbg_word !== 64'h0000_0000_FF00_0006) begin errors++; $display("FAIL sb3_dbg0: got %h expected 00000000ff000006", a_dbg_word); end
    access(0, 1'b0, 3'b001, 64'd2, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FF00) begin errors++; $display("FAIL lh2: got %h expected ffffffffffffff00", rd); end
    access(0, 1'b0, 3'b101, 64'd2, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'h0000_0000_0000_FF00) begin errors++; $display("FAIL lhu2: got %h expected ff00", rd); end
  endtask

  task automatic test_word();
    logic [63:0] rd; logic er; int lat;
    access(0, 1'b1, 3'b010, 64'd16, 64'hDEAD_BEEF_8000_0000, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw16_err: got %b expected 0", er); end
    access(0, 1'b0, 3'b010, 64'd16, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL lw16: got %h expected ffffffff80000000", rd); end
    access(0, 1'b0, 3'b110, 64'd16, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL lwu16: got %h expected 80000000", rd); end
    access(0, 1'b0, 3'b011, 64'd16, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL ld16: got %h expected 80000000", rd); end
    access(0, 1'b1, 3'b001, 64'd42, 64'hAAAA_AAAA_AAAA_1234, rd, er, lat);
    a_dbg_addr = 8'd47; #1;
    checks++; if (a_dbg_word !== 64'h0000_0000_1234_0001) begin errors++; $display("FAIL sh42_dbg40: got %h expected 0000000012340001", a_dbg_word); end
    access(0, 1'b0, 3'b001, 64'd42, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'h0000_0000_0000_1234) begin errors++; $display("FAIL lh42: got %h expected 1234", rd); end
  endtask

  task automatic test_errors();
    logic [63:0] rd; logic er; int lat;
    access(0, 1'b0, 3'b001, 64'd5, 64'd0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 64'd0 || lat !== 1) begin errors++; $display("FAIL lh5_misalign: got err=%b rdata=%h lat=%0d expected 1/0/1", er, rd, lat); end
    access(0, 1'b1, 3'b011, 64'd252, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL sd252_err: got %b expected 1", er); end
    a_dbg_addr = 8'd248; #1;
    checks++; if (a_dbg_word !== 64'd0) begin errors++; $display("FAIL sd252_dbg248: got %h expected 0", a_dbg_word); end
    access(0, 1'b0, 3'b111, 64'd0, 64'd0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL ld_f3_111: got err=%b rdata=%h expected 1/0", er, rd); end
    access(0, 1'b1, 3'b100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL st_f3_100: got %b expected 1", er); end
    a_dbg_addr = 8'd0; #1;
    checks++; if (a_dbg_word !== 64'h0000_0000_FF00_0006) begin errors++; $display("FAIL st_f3_100_dbg0: got %h expected 00000000ff000006", a_dbg_word); end
    access(0, 1'b0, 3'b011, 64'd256, 64'd0, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL ld256_err: got %b expected 1", er); end
    access(0, 1'b0, 3'b011, 64'h0000_0001_0000_0000, 64'd0, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL ld_high_addr_err: got %b expected 1", er); end
    access(0, 1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL ld_wrap_err: got %b expected 1", er); end
    access(0, 1'b0, 3'b011, 64'd248, 64'd0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 64'd0) begin errors++; $display("FAIL ld248_edge: got err=%b rdata=%h expected 0/0", er, rd); end
    access(0, 1'b1, 3'b000, 64'd255, 64'h0000_0000_0000_005A, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sb255_err: got %b expected 0", er); end
    a_dbg_addr = 8'd248; #1;
    checks++; if (a_dbg_word !== 64'h5A00_0000_0000_0000) begin errors++; $display("FAIL sb255_dbg248: got %h expected 5a00000000000000", a_dbg_word); end
  endtask

  task automatic test_latency3();
    logic [63:0] rd; logic er; int lat;
    checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL lat3_ready_idle: got %b expected 1", b_req_ready); end
    drive_req(1, 1'b0, 3'b011, 64'd0, 64'd0);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (b_req_ready !== (k == 4)) begin errors++; $display("FAIL lat3_ready_c%0d: got %b expected %b", k, b_req_ready, (k == 4)); end
      checks++;
      if (b_rsp_valid !== (k == 3)) begin errors++; $display("FAIL lat3_valid_c%0d: got %b expected %b", k, b_rsp_valid, (k == 3)); end
      checks++;
      if (b_rsp_rdata !== ((k == 3) ? 64'd6 : 64'd0)) begin errors++; $display("FAIL lat3_rdata_c%0d: got %h expected %h", k, b_rsp_rdata, (k == 3) ? 64'd6 : 64'd0); end
      @(posedge clk); #1;
    end
    access(1, 1'b1, 3'b000, 64'd9, 64'h0000_0000_0000_0077, rd, er, lat);
    checks++; if (lat !== 1 || er !== 1'b0) begin errors++; $display("FAIL lat3_store: got lat=%0d err=%b expected 1/0", lat, er); end
  endtask

  task automatic test_reset_busy();
    logic [63:0] rd; logic er; int lat;
    bit seen;
    drive_req(1, 1'b0, 3'b011, 64'd8, 64'd0);
    checks++; if (b_req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b expected 0", b_req_ready); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin errors++; $display("FAIL busy_reset_now: got ready=%b valid=%b expected 1/0", b_req_ready, b_rsp_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (b_rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL busy_dropped: got valid seen=%b expected 0", seen); end
    checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL busy_ready_after: got %b expected 1", b_req_ready); end
    b_dbg_addr = 8'd8; a_dbg_addr = 8'd16; #1;
    checks++; if (b_dbg_word !== 64'h0000_0000_0000_7736) begin errors++; $display("FAIL busy_mem_kept: got %h expected 7736", b_dbg_word); end
    checks++; if (a_dbg_word !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL reset_mem_kept: got %h expected 80000000", a_dbg_word); end
    access(1, 1'b0, 3'b011, 64'd8, 64'd0, rd, er, lat);
    checks++; if (lat !== 3 || rd !== 64'h7736) begin errors++; $display("FAIL busy_reload: got lat=%0d rdata=%h expected 3/7736", lat, rd); end
  endtask

  initial begin
    reset_n = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_funct3 = 3'b000; a_req_addr = '0; a_req_wdata = '0; a_dbg_addr = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_funct3 = 3'b000; b_req_addr = '0; b_req_wdata = '0; b_dbg_addr = '0;
    test_reset();
    test_load();
    test_byte();
    test_word();
    test_errors();
    test_latency3();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
